// File: rtl/keypad_entry_ctrl_pkg.sv
// keypad_pkg: shared types and constants for the keypad entry controller.
//   state_e        scan/debounce FSM states
//   KEY_CLEAR      code of the clear key
//   KEY_ENTER      code of the enter key
//   KEY_TABLE_4X3  index-to-code map for the default 4x3 telephone layout
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam int KEY_TABLE_SIZE = 12;

  // Row-major: 1 2 3 / 4 5 6 / 7 8 9 / clear 0 enter
  localparam logic [3:0] KEY_TABLE_4X3 [KEY_TABLE_SIZE] = '{
    4'h1, 4'h2, 4'h3,
    4'h4, 4'h5, 4'h6,
    4'h7, 4'h8, 4'h9,
    KEY_CLEAR, 4'h0, KEY_ENTER
  };

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// keypad_entry_ctrl_if: result bus from the keypad controller.
//   key_valid   one-cycle pulse per accepted press
//   key_code    code of the last accepted key
//   digit_buf   entered digits, newest in [3:0]
//   num_count   number of digits held
//   start_game  sticky flag set by enter
// master = controller side (drives), slave = consumer side.
interface keypad_entry_ctrl_if #(
  parameter int DIGITS = 2
);
  localparam int NW = $clog2(DIGITS + 1);

  logic                  key_valid;
  logic [3:0]            key_code;
  logic [4*DIGITS-1:0]   digit_buf;
  logic [NW-1:0]         num_count;
  logic                  start_game;

  modport master (
    output key_valid, key_code, digit_buf, num_count, start_game
  );

  modport slave (
    input key_valid, key_code, digit_buf, num_count, start_game
  );
endinterface

// File: rtl/keypad_entry_ctrl_decode.sv
// keypad_decode: combinational key index to key code translation.
//   key_idx_i   row*COLS + column of the pressed key
//   key_code_o  telephone-layout code for a 4x3 pad, otherwise the raw index
module keypad_decode
  import keypad_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 3
) (
  input  logic [3:0] key_idx_i,
  output logic [3:0] key_code_o
);

  localparam bit USE_TABLE = (ROWS == 4) && (COLS == 3);

  always_comb begin
    key_code_o = key_idx_i;
    if (USE_TABLE && (key_idx_i < 4'd12)) begin
      key_code_o = KEY_TABLE_4X3[key_idx_i];
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: matrix keypad scanner with press/release debounce and a
// small digit entry buffer.
//   clk            rising-edge clock
//   rstn           synchronous active-low reset
//   keyboard_cols  column sense lines, active high
//   keyboard_rows  one-hot row drive
//   bus            result bus (key_valid, key_code, digit_buf, num_count,
//                  start_game)
//
// state          | meaning
// ST_SCAN        | rows rotate, waiting for any column
// ST_DEB_PRESS   | rows frozen, counting stable cycles of the latched key
// ST_HELD        | key accepted, waiting for all columns low
// ST_DEB_RELEASE | counting all-low cycles before scanning again
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 3,
  parameter int DEBOUNCE_CYCLES = 800000,
  parameter int DIGITS          = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [COLS-1:0]     keyboard_cols,
  output logic [ROWS-1:0]     keyboard_rows,
  keypad_entry_ctrl_if.master bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [NW-1:0] NUM_MAX  = NW'(DIGITS);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [3:0]      idx_q, idx_d;
  logic            accept;
  logic            kv_q;
  logic [3:0]      code_q;
  logic [BW-1:0]   buf_q;
  logic [NW-1:0]   num_q;
  logic            start_q;

  logic            col_hit;
  logic [3:0]      row_sel, col_sel, cur_idx, dec_code;

  keypad_decode #(.ROWS(ROWS), .COLS(COLS)) u_decode (
    .key_idx_i  (idx_q),
    .key_code_o (dec_code)
  );

  // Descending scan so the lowest asserted column wins.
  always_comb begin
    row_sel = '0;
    col_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_q[r]) row_sel = 4'(r);
    end
    for (int c = COLS - 1; c >= 0; c--) begin
      if (keyboard_cols[c]) col_sel = 4'(c);
    end
    col_hit = |keyboard_cols;
    cur_idx = 4'(int'(row_sel) * COLS + int'(col_sel));
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        // A started game locks the scanner: no rotation, no new presses.
        if (!start_q) begin
          if (col_hit) begin
            state_d = ST_DEB_PRESS;
            idx_d   = cur_idx;
            cnt_d   = '0;
          end else begin
            rows_d = {rows_q[ROWS-2:0], rows_q[ROWS-1]};
          end
        end
      end
      ST_DEB_PRESS: begin
        if (!col_hit || (cur_idx != idx_q)) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!col_hit) begin
          state_d = ST_DEB_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_DEB_RELEASE: begin
        if (col_hit) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_SCAN;
      cnt_q   <= '0;
      rows_q  <= ROWS'(1);
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rows_q  <= rows_d;
      idx_q   <= idx_d;
    end
  end

  // The accepted key is applied to the buffer one cycle after key_valid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      kv_q    <= 1'b0;
      code_q  <= '0;
      buf_q   <= '0;
      num_q   <= '0;
      start_q <= 1'b0;
    end else begin
      kv_q <= accept;
      if (accept) code_q <= dec_code;
      if (kv_q) begin
        if (code_q <= 4'd9) begin
          if (num_q < NUM_MAX) begin
            buf_q <= (buf_q << 4) | BW'(code_q);
            num_q <= num_q + 1'b1;
          end else begin
            buf_q <= BW'(code_q);
            num_q <= NW'(1);
          end
        end else if (code_q == KEY_CLEAR) begin
          buf_q <= '0;
          num_q <= '0;
        end else if ((code_q == KEY_ENTER) && (num_q != '0)) begin
          start_q <= 1'b1;
        end
      end
    end
  end

  assign keyboard_rows  = rows_q;
  assign bus.key_valid  = kv_q;
  assign bus.key_code   = code_q;
  assign bus.digit_buf  = buf_q;
  assign bus.num_count  = num_q;
  assign bus.start_game = start_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Scoreboard bench for keypad_entry_ctrl (4x3 pad, 4-cycle debounce, 2 digits).
// A physical keypad model closes the row/column loop; presses are either
// clearly too short to pass debounce or clearly long enough, and every long
// press pushes the expected result of a digit-entry reference model.
module tb_keypad_entry_ctrl;
  import keypad_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 3;
  localparam int DEB    = 4;
  localparam int DIGITS = 2;
  localparam int LONG_MIN = ROWS + DEB + 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [COLS-1:0] cols;
  logic [ROWS-1:0] rows;

  keypad_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

  keypad_entry_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .DEBOUNCE_CYCLES(DEB), .DIGITS(DIGITS)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .keyboard_cols (cols),
    .keyboard_rows (rows),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  logic key_dn;
  int   key_r, key_c;

  always_comb begin
    cols = '0;
    if (key_dn && rows[key_r]) cols[key_c] = 1'b1;
  end

  typedef struct {
    int code;
    int dbuf;
    int cnt;
    int start;
  } exp_t;

  exp_t q[$];
  int   m_buf, m_cnt, m_start;
  int   errors = 0;
  int   checks = 0;
  int   pcyc = 0;
  int   last_kv = 0;
  bit   pend = 1'b0;
  exp_t cur;

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int code_of(int r, int c);
    int i;
    i = r * COLS + c;
    if (i < 9) return i + 1;
    if (i == 9) return 10;
    if (i == 10) return 0;
    return 11;
  endfunction

  function automatic void model_accept(int code);
    exp_t e;
    if (m_start != 0) return;
    if (code <= 9) begin
      if (m_cnt < DIGITS) begin
        m_buf = (m_buf * 16 + code) % 256;
        m_cnt = m_cnt + 1;
      end else begin
        m_buf = code;
        m_cnt = 1;
      end
    end else if (code == 10) begin
      m_buf = 0;
      m_cnt = 0;
    end else if (code == 11 && m_cnt >= 1) begin
      m_start = 1;
    end
    e.code  = code;
    e.dbuf  = m_buf;
    e.cnt   = m_cnt;
    e.start = m_start;
    q.push_back(e);
  endfunction

  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (pend) begin
      pend = 1'b0;
      chk("digit_buf", int'(bus.digit_buf), cur.dbuf);
      chk("num_count", int'(bus.num_count), cur.cnt);
      chk("start_game", int'(bus.start_game), cur.start);
    end
    if (bus.key_valid) begin
      last_kv = pcyc;
      if (q.size() == 0) begin
        chk("unexpected_key_valid", int'(bus.key_valid), 0);
      end else begin
        cur = q.pop_front();
        chk("key_code", int'(bus.key_code), cur.code);
        chk("start_at_key_valid", int'(bus.start_game), 0);
        pend = 1'b1;
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int r, int c, int dur);
    key_r  = r;
    key_c  = c;
    key_dn = 1'b1;
    if (dur >= LONG_MIN) model_accept(code_of(r, c));
    idle(dur);
    key_dn = 1'b0;
  endtask

  task automatic press_rel(int r, int c, int dur);
    press(r, c, dur);
    idle(8);
  endtask

  task automatic do_reset();
    chk("queue_drained", q.size(), 0);
    rstn = 1'b0;
    m_buf = 0;
    m_cnt = 0;
    m_start = 0;
    idle(2);
    rstn = 1'b1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rows"}, int'(rows), 1);
    chk({tag, "_key_valid"}, int'(bus.key_valid), 0);
    chk({tag, "_key_code"}, int'(bus.key_code), 0);
    chk({tag, "_digit_buf"}, int'(bus.digit_buf), 0);
    chk({tag, "_num_count"}, int'(bus.num_count), 0);
    chk({tag, "_start_game"}, int'(bus.start_game), 0);
  endtask

  initial begin
    int p0, k, dur, waited;
    bit seen;
    rstn = 1'b0;
    key_dn = 1'b0;
    key_r = 0;
    key_c = 0;
    m_buf = 0;
    m_cnt = 0;
    m_start = 0;
    idle(3);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    idle(2);

    // Key 5 held 10 cycles.
    press_rel(1, 1, 10);
    idle(4);

    // Bounce 2 high / 1 low / 2 high, then a real press.
    p0 = pcyc;
    press(1, 1, 2);
    idle(1);
    press(1, 1, 2);
    idle(1);
    press_rel(1, 1, 12);
    idle(4);
    chk("bounce_latency_ok", int'(last_kv >= p0 + 11), 1);

    // 3, 7, 9: buffer rolls over on the third digit.
    do_reset();
    press_rel(0, 2, 10);
    press_rel(2, 0, 10);
    press_rel(2, 2, 10);
    idle(4);

    // 4, 2, clear, then enter with an empty buffer.
    do_reset();
    press_rel(1, 0, 10);
    press_rel(0, 1, 10);
    press_rel(3, 0, 10);
    press_rel(3, 2, 10);
    idle(4);
    chk("enter_empty_no_start", int'(bus.start_game), 0);

    // 1 then enter starts the game; scanner locks on the enter row.
    do_reset();
    press_rel(0, 0, 10);
    press_rel(3, 2, 10);
    chk("start_game_set", int'(bus.start_game), 1);
    chk("rows_frozen_a", int'(rows), 8);
    idle(5);
    chk("rows_frozen_b", int'(rows), 8);
    press_rel(1, 2, 14);
    chk("rows_frozen_c", int'(rows), 8);
    chk("start_game_sticky", int'(bus.start_game), 1);

    // Reset during the second DEB_PRESS cycle discards the press.
    do_reset();
    press_rel(2, 1, 10);
    key_r = 1;
    key_c = 1;
    key_dn = 1'b1;
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 20) begin
      if (cols != '0) seen = 1'b1;
      else begin
        idle(1);
        waited++;
      end
    end
    chk("deb_press_reached", int'(seen), 1);
    idle(2);
    rstn = 1'b0;
    key_dn = 1'b0;
    m_buf = 0;
    m_cnt = 0;
    m_start = 0;
    idle(1);
    chk_reset_outputs("mid_debounce");
    rstn = 1'b1;
    idle(15);

    // Randomized presses against the reference model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 11);
      if ($urandom_range(0, 3) != 0) dur = $urandom_range(LONG_MIN, LONG_MIN + 6);
      else dur = $urandom_range(1, DEB);
      press(k / COLS, k % COLS, dur);
      idle($urandom_range(8, 12));
      if (m_start != 0) begin
        idle(4);
        do_reset();
      end
    end
    idle(12);
    chk("final_queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
